// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the word PC, issues reads to a 1-cycle synchronous imem,
// buffers returned words and hands them to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [8:0] RESET_PC = 9'd0,
    parameter int         DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output logic [8:0]  imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [8:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [8:0]  out_pc
);

    typedef logic [8:0]  pc_t;
    typedef logic [31:0] ir_t;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    pc_t              fetch_pc_q, fetch_pc_d;
    pc_t              issue_pc_q, issue_pc_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    ir_t              buf_ir_q [DEPTH];
    pc_t              buf_pc_q [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occupancy;

    assign out_valid = (count_q != '0) & !redirect;
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & !redirect;

    // Slots already committed after this cycle's pop; a pop frees room for a same-cycle issue.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = !reset & !redirect & (occupancy < OCC_W'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;
    assign out_ir    = buf_ir_q[rd_ptr_q];
    assign out_pc    = buf_pc_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 9'd1;
                issue_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_ir_q[i] <= '0;
                buf_pc_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push) begin
                buf_ir_q[wr_ptr_q] <= imem_data;
                buf_pc_q[wr_ptr_q] <= issue_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and 1FE) each with a 1-cycle memory model;
// delivered pcs are checked against an expected-next-pc stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        out_ready;

    logic        imem_en, w_imem_en;
    logic [8:0]  imem_addr, w_imem_addr;
    logic [31:0] imem_data, w_imem_data;
    logic        out_valid, w_out_valid;
    logic [31:0] out_ir, w_out_ir;
    logic [8:0]  out_pc, w_out_pc;

    int          n_run = 0;
    int          n_fail = 0;
    logic [8:0]  exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(9'd0), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(9'h1FE), .DEPTH(2)) dut_w (
        .clk(clk), .reset(reset), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
        .imem_data(w_imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_ir(w_out_ir), .out_pc(w_out_pc)
    );

    function automatic logic [31:0] word_of(input logic [8:0] a);
        return 32'h1000_0000 + {23'd0, a};
    endfunction

    // Synchronous memory: data for an enabled read appears the next cycle, junk otherwise.
    always @(posedge clk) begin
        imem_data   <= imem_en   ? word_of(imem_addr)   : $urandom;
        w_imem_data <= w_imem_en ? word_of(w_imem_addr) : $urandom;
    end

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 9'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_run++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b want 0", imem_en); end
        n_run++; if (imem_addr !== 9'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", imem_addr); end
        n_run++; if (w_imem_addr !== 9'h1FE) begin n_fail++; $display("FAIL reset_addr_w: got %h want 1fe", w_imem_addr); end
        n_run++; if (out_ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", out_ir); end
        n_run++; if (out_pc !== 9'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [8:0] epc, wpc;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_run++; if (imem_en !== 1'b1 || imem_addr !== 9'(c)) begin
                n_fail++; $display("FAIL stream_issue c=%0d: got en=%0b addr=%h want en=1 addr=%h", c, imem_en, imem_addr, 9'(c));
            end
            n_run++; if (out_valid !== (c >= 2)) begin
                n_fail++; $display("FAIL stream_valid c=%0d: got %0b want %0b", c, out_valid, (c >= 2));
            end
            if (c >= 2) begin
                epc = 9'(c - 2);
                wpc = 9'h1FE + 9'(c - 2);
                n_run++; if (out_pc !== epc || out_ir !== word_of(epc)) begin
                    n_fail++; $display("FAIL stream_data c=%0d: got %h/%h want %h/%h", c, out_pc, out_ir, epc, word_of(epc));
                end
                n_run++; if (w_out_valid !== 1'b1 || w_out_pc !== wpc || w_out_ir !== word_of(wpc)) begin
                    n_fail++; $display("FAIL wrap_data c=%0d: got v=%0b %h/%h want v=1 %h/%h", c, w_out_valid, w_out_pc, w_out_ir, wpc, word_of(wpc));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        do_reset();
        exp_pc = 9'h0;
        for (int c = 0; c < 17; c++) begin
            out_ready = (c < 3) || (c >= 11);
            @(negedge clk);
            if (c >= 3 && c < 11) begin
                n_run++; if (imem_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== exp_pc) begin
                    n_fail++; $display("FAIL stall c=%0d: got en=%0b v=%0b pc=%h want en=0 v=1 pc=%h", c, imem_en, out_valid, out_pc, exp_pc);
                end
            end
            if (c >= 11) begin
                n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL release_bubble c=%0d: got valid %0b want 1", c, out_valid); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_run++; if (out_pc !== exp_pc || out_ir !== word_of(exp_pc)) begin
                    n_fail++; $display("FAIL bp_data c=%0d: got %h/%h want %h/%h", c, out_pc, out_ir, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 9'd1;
                pops++;
            end
            @(posedge clk); #1;
        end
        n_run++; if (pops != 7) begin n_fail++; $display("FAIL bp_pops: got %0d want 7", pops); end
        out_ready = 1'b1;
    endtask

    task automatic test_redirect();
        logic [8:0] tgt;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            tgt = (v == 0) ? 9'h40 : 9'($urandom);
            out_ready = (v == 0);
            repeat (6) begin @(posedge clk); #1; end
            redirect = 1'b1; redirect_pc = tgt; out_ready = 1'b1;
            @(negedge clk);
            n_run++; if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
                n_fail++; $display("FAIL redir_cycle v=%0d: got valid=%0b en=%0b want 0/0", v, out_valid, imem_en);
            end
            @(posedge clk); #1 redirect = 1'b0; redirect_pc = $urandom;
            @(negedge clk);
            n_run++; if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== tgt) begin
                n_fail++; $display("FAIL redir_issue v=%0d: got v=%0b en=%0b addr=%h want 0/1/%h", v, out_valid, imem_en, imem_addr, tgt);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale v=%0d: got valid %0b pc %h want 0", v, out_valid, out_pc); end
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                n_run++; if (out_valid !== 1'b1 || out_pc !== tgt + 9'(k) || out_ir !== word_of(tgt + 9'(k))) begin
                    n_fail++; $display("FAIL redir_data v=%0d k=%0d: got v=%0b %h/%h want v=1 %h", v, k, out_valid, out_pc, out_ir, tgt + 9'(k));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (5) begin @(posedge clk); #1; end
        redirect = 1'b1; redirect_pc = 9'h10;
        @(posedge clk); #1 redirect_pc = 9'h20;
        @(negedge clk);
        n_run++; if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
            n_fail++; $display("FAIL b2b_quiet: got valid=%0b en=%0b want 0/0", out_valid, imem_en);
        end
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        n_run++; if (imem_en !== 1'b1 || imem_addr !== 9'h20) begin
            n_fail++; $display("FAIL b2b_issue: got en=%0b addr=%h want 1/020", imem_en, imem_addr);
        end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_run++; if (out_valid !== 1'b1 || out_pc !== 9'h20 || out_ir !== word_of(9'h20)) begin
            n_fail++; $display("FAIL b2b_data: got v=%0b %h/%h want v=1 020", out_valid, out_pc, out_ir);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_run++; if (out_valid !== 1'b0 || imem_addr !== 9'h0 || out_pc !== 9'h0 || out_ir !== 32'h0) begin
            n_fail++; $display("FAIL midreset_out: got v=%0b addr=%h pc=%h ir=%h want 0/000/000/0", out_valid, imem_addr, out_pc, out_ir);
        end
        n_run++; if (w_out_valid !== 1'b0 || w_imem_addr !== 9'h1FE) begin
            n_fail++; $display("FAIL midreset_w: got v=%0b addr=%h want 0/1fe", w_out_valid, w_imem_addr);
        end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_run++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_ir !== word_of(9'h0)) begin
            n_fail++; $display("FAIL midreset_data: got v=%0b %h/%h want v=1 000/%h", out_valid, out_pc, out_ir, word_of(9'h0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int r;
        int pops = 0;
        do_reset();
        exp_pc = 9'h0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            reset       = (r < 1);
            redirect    = !reset && (r < 6);
            redirect_pc = 9'($urandom);
            out_ready   = ($urandom_range(0, 99) < 65);
            @(negedge clk);
            if (reset) begin
                exp_pc = 9'h0;
            end else if (redirect) begin
                n_run++; if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_redirect c=%0d: got valid=%0b en=%0b want 0/0", c, out_valid, imem_en);
                end
                exp_pc = redirect_pc;
            end else if (out_valid === 1'b1 && out_ready) begin
                n_run++; if (out_pc !== exp_pc || out_ir !== word_of(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_data c=%0d: got %h/%h want %h/%h", c, out_pc, out_ir, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 9'd1;
                pops++;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; redirect = 1'b0; out_ready = 1'b1;
        n_run++; if (pops < 800) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >= 800", pops); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 9'h0; out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
